uart_tx: RTL

Serial transmitter directly downstream of the text/keypad controller. Accepts one byte per Data/Data_rdy strobe and shifts it out LSB-first as an 8-bit asynchronous serial frame with optional parity. Drives transEna high while idle and able to accept a byte. The controller uses transEna to pace ROM and keypad characters.

---
 rtl/uart_tx.sv | 82 ++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8-bit LSB-first asynchronous serial transmitter with optional parity and 1 or 2 stop bits.
// transEna is high only while idle and able to accept a byte on Data_rdy.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Data,
  input  logic       Data_rdy,
  output logic       transEna,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_stop;
  logic          r_tx;
  logic          r_ena;
  logic          w_tc;
  assign w_tc     = r_cnt == CW'(CLKS_PER_BIT - 1);
  assign tx       = r_tx;
  assign transEna = r_ena;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_stop  <= 1'b0;
      r_tx    <= 1'b1;
      r_ena   <= 1'b1;
    end else begin
      if (r_state != IDLE) r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
      case (r_state)
        IDLE: if (Data_rdy) begin
          r_shift <= Data;
          r_par   <= ^Data ^ (PARITY == 2);
          r_ena   <= 1'b0;
          r_tx    <= 1'b0;
          r_cnt   <= '0;
          r_state <= START;
        end
        START: if (w_tc) begin
          r_tx    <= r_shift[0];
          r_idx   <= '0;
          r_state <= DATA;
        end
        DATA: if (w_tc) begin
          if (r_idx == 3'd7) begin
            r_tx    <= PARITY != 0 ? r_par : 1'b1;
            r_stop  <= 1'b0;
            r_state <= PARITY != 0 ? PAR : STOP;
          end else begin
            r_shift <= r_shift >> 1;
            r_tx    <= r_shift[1];
            r_idx   <= r_idx + 1'b1;
          end
        end
        PAR: if (w_tc) begin
          r_tx    <= 1'b1;
          r_stop  <= 1'b0;
          r_state <= STOP;
        end
        STOP: if (w_tc) begin
          // r_stop marks the second stop bit when two are configured
          if (r_stop || STOP_BITS == 1) begin
            r_ena   <= 1'b1;
            r_state <= IDLE;
          end else r_stop <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
